bit_sequence_generator: RTL and testbench

Serial stimulus source for the sequence-detector datapath. It accepts a parallel pattern word plus a bit length through a valid/ready handshake and shifts the pattern out one bit per clock, index 0 first. Its output drives the detector's serial test input (`sig_to_test`), so on-chip self-test does not depend on a bench. A one-entry pending buffer allows back-to-back frames with no idle cycle between them.

---
 rtl/bit_sequence_generator_pkg.sv | 12 +
 rtl/bit_sequence_generator_if.sv | 28 ++
 rtl/bit_sequence_generator_pending_buf.sv | 45 ++++
 rtl/bit_sequence_generator.sv | 129 ++++++++++++
 tb/tb_bit_sequence_generator.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_sequence_generator_pkg.sv
// Shared types and constants for the serial bit-sequence generator.
package bitseq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_LEN_DEFAULT = 32;
  localparam int FRAME_CNT_W     = 8;

endpackage

// File: rtl/bit_sequence_generator_if.sv
// Load handshake bundle: pattern word plus bit length with valid/ready.
interface bit_sequence_generator_if
  import bitseq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
);

  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_data;
  logic [CNT_W-1:0]   load_len;

  modport master (
    output load_valid,
    output load_data,
    output load_len,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_len,
    output load_ready
  );

endinterface

// File: rtl/bit_sequence_generator_pending_buf.sv
// One-entry holding register for the frame queued behind the one being shifted.
module bitseq_pending_buf
  import bitseq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_take,
  input  logic [MAX_LEN-1:0] i_data,
  input  logic [CNT_W-1:0]   i_len,
  output logic               o_full,
  output logic [MAX_LEN-1:0] o_data,
  output logic [CNT_W-1:0]   o_len
);

  logic               r_full;
  logic [MAX_LEN-1:0] r_data;
  logic [CNT_W-1:0]   r_len;

  // Load and take never coincide: a load needs the buffer empty, a take needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
      r_len  <= i_len;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_len  = r_len;

endmodule

// File: rtl/bit_sequence_generator.sv
// Serial stimulus source: shifts a loaded pattern out LSB first, with a one-entry
// pending buffer so consecutive frames run without an idle cycle.
module bit_sequence_generator
  import bitseq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  bit_sequence_generator_if.slave load_if,
  output logic                   sig_out,
  output logic                   bit_valid,
  output logic                   frame_last,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frames_sent
);

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;
  endfunction

  state_t                 r_state;
  state_t                 w_next_state;
  logic [MAX_LEN-1:0]     r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sig_out;
  logic [FRAME_CNT_W-1:0] r_frames;

  logic                   w_accept;
  logic                   w_len_zero;
  logic [CNT_W-1:0]       w_len_eff;
  logic                   w_complete;
  logic                   w_direct;
  logic                   w_pend_load;
  logic                   w_take;
  logic                   w_advance;
  logic                   w_pend_full;
  logic [MAX_LEN-1:0]     w_pend_data;
  logic [CNT_W-1:0]       w_pend_len;

  assign w_accept   = load_if.load_valid && load_if.load_ready;
  assign w_len_zero = (load_if.load_len == '0);
  assign w_len_eff  = clamp_len(load_if.load_len);
  assign w_complete = (r_state == SHIFT) && ena && (r_cnt == CNT_W'(1));

  // Zero-length loads are consumed by the handshake but never stored anywhere.
  assign w_direct    = w_accept && !w_len_zero && ((r_state == IDLE) || w_complete);
  assign w_pend_load = w_accept && !w_len_zero && (r_state == SHIFT) && !w_complete;
  assign w_take      = w_complete && w_pend_full;
  assign w_advance   = (r_state == SHIFT) && ena && !w_complete;

  bitseq_pending_buf #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) u_pend (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pend_load),
    .i_take (w_take),
    .i_data (load_if.load_data),
    .i_len  (w_len_eff),
    .o_full (w_pend_full),
    .o_data (w_pend_data),
    .o_len  (w_pend_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_direct) w_next_state = SHIFT;
      SHIFT:   if (w_complete && !w_take && !w_direct) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // r_cnt counts the bits still to retire, including the one on sig_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_out <= 1'b0;
      r_cnt     <= '0;
      r_frames  <= '0;
    end else begin
      if (w_complete) begin
        r_frames <= r_frames + FRAME_CNT_W'(1);
      end
      if (w_direct) begin
        r_sig_out <= load_if.load_data[0];
        r_cnt     <= w_len_eff;
      end else if (w_take) begin
        r_sig_out <= w_pend_data[0];
        r_cnt     <= w_pend_len;
      end else if (w_complete) begin
        r_sig_out <= 1'b0;
        r_cnt     <= '0;
      end else if (w_advance) begin
        r_sig_out <= r_shift[0];
        r_cnt     <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_direct) begin
      r_shift <= load_if.load_data >> 1;
    end else if (w_take) begin
      r_shift <= w_pend_data >> 1;
    end else if (w_advance) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign load_if.load_ready = !w_pend_full;
  assign sig_out            = r_sig_out;
  assign bit_valid          = (r_state == SHIFT) && ena;
  assign frame_last         = bit_valid && (r_cnt == CNT_W'(1));
  assign busy               = (r_state == SHIFT) || w_pend_full;
  assign frames_sent        = r_frames;

endmodule

// File: tb/tb_bit_sequence_generator.sv
// Scoreboard bench: accepted loads queue their expected bits; a negedge monitor
// pops and compares every presented bit and tracks the frame count.
module tb_bit_sequence_generator;

  localparam int MAX_LEN = 32;
  localparam int CNT_W   = 6;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       sig_out, bit_valid, frame_last, busy;
  logic [7:0] frames_sent;

  exp_t       sb_q[$];
  logic [7:0] sb_frames = 8'd0;
  int         checks    = 0;
  int         errors    = 0;
  int         valid_cnt = 0;
  int         run_cur   = 0;
  int         last_run  = 0;
  logic       stall_req = 1'b0;
  logic       rand_ena  = 1'b0;

  bit_sequence_generator_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) lif ();

  bit_sequence_generator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .load_if     (lif),
    .sig_out     (sig_out),
    .bit_valid   (bit_valid),
    .frame_last  (frame_last),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (stall_req)     ena = 1'b0;
    else if (rand_ena) ena = ($urandom_range(0, 3) != 0);
    else               ena = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("frames_sent", frames_sent, sb_frames);
      if (bit_valid) begin
        valid_cnt++;
        run_cur++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit sig_out=%0b with no expected bit queued at %0t", sig_out, $time);
        end else begin
          e = sb_q.pop_front();
          check("sig_out", sig_out, e.b);
          check("frame_last", frame_last, e.last);
          if (e.last) sb_frames = sb_frames + 8'd1;
        end
      end else begin
        check("frame_last_gated", frame_last, 1'b0);
        if (run_cur != 0) last_run = run_cur;
        run_cur = 0;
      end
    end else begin
      run_cur = 0;
    end
  end

  task automatic send(input logic [31:0] d, input int len);
    int n;
    int eff;
    lif.load_data  = d;
    lif.load_len   = CNT_W'(len);
    lif.load_valid = 1'b1;
    n = 0;
    while (!lif.load_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!lif.load_ready) begin
      checks++;
      errors++;
      $display("FAIL load_accept_timeout load_ready=0 required=1");
    end else begin
      eff = (len > MAX_LEN) ? MAX_LEN : len;
      for (int k = 0; k < eff; k++) sb_q.push_back('{b: d[k], last: (k == eff - 1)});
    end
    @(posedge clk); #1;
    lif.load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb_q.size() != 0) && n < 3000);
    check("drain_done", {busy, (sb_q.size() != 0)}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sig_out"}, sig_out, 1'b0);
    check({tag, "_bit_valid"}, bit_valid, 1'b0);
    check({tag, "_frame_last"}, frame_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_load_ready"}, lif.load_ready, 1'b1);
    check({tag, "_frames_sent"}, frames_sent, 8'd0);
  endtask

  initial begin
    int base;
    int n;
    int len;
    logic [31:0] d;
    logic held;

    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Pattern run
    send(32'h00CAE8C8, 24);
    wait_idle();
    check("pattern_frames", frames_sent, 8'd1);

    // Back-to-back frames through the pending buffer
    send(32'b1010, 4);
    send(32'b011, 3);
    check("b2b_load_ready_low", lif.load_ready, 1'b0);
    check("b2b_busy", busy, 1'b1);
    wait_idle();
    check("b2b_contiguous_run", last_run, 7);
    check("b2b_frames", frames_sent, 8'd3);

    // Enable stall mid-frame
    base = valid_cnt;
    send($urandom, 16);
    repeat (4) @(negedge clk);
    stall_req = 1'b1;
    @(posedge clk); #2;
    held = sig_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_bit_valid", bit_valid, 1'b0);
      check("stall_sig_hold", sig_out, held);
      if (i == 2) stall_req = 1'b0;
    end
    wait_idle();
    check("stall_bit_total", valid_cnt - base, 16);

    // Zero length is swallowed
    base = valid_cnt;
    send(32'hFFFF_FFFF, 0);
    repeat (4) @(negedge clk);
    check("len0_no_bits", valid_cnt - base, 0);
    check("len0_idle", busy, 1'b0);
    check("len0_frames", frames_sent, 8'd4);
    @(posedge clk); #1;

    // Oversize length is clamped
    base = valid_cnt;
    send($urandom, 40);
    wait_idle();
    check("len40_bits", valid_cnt - base, 32);

    // Randomized frames with random enable
    rand_ena = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 9);
      if (n == 0)      len = 0;
      else if (n == 1) len = $urandom_range(33, 63);
      else             len = $urandom_range(1, 32);
      send($urandom, len);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();
    rand_ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame with a pending frame queued
    base = valid_cnt;
    send($urandom, 24);
    send($urandom, 8);
    n = 0;
    while ((valid_cnt - base) < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_bit5", (valid_cnt - base) >= 6, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    sb_q.delete();
    sb_frames = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    base = valid_cnt;
    repeat (30) @(negedge clk);
    check("post_rst_no_bits", valid_cnt - base, 0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_frames", frames_sent, 8'd0);
    @(posedge clk); #1;

    // Frame counter wrap
    for (int f = 0; f < 255; f++) send($urandom, 1);
    wait_idle();
    check("wrap_255", frames_sent, 8'd255);
    send($urandom, 1);
    wait_idle();
    check("wrap_0", frames_sent, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
